// File: rtl/trace_capture_engine.sv
// Trace capture engine: trigger FSM and address-range filter feeding a packet FIFO on AXI-Stream.
// Packets are dropped and counted when the FIFO is full; the core is never stalled.
module trace_capture_engine #(
  parameter int XLEN       = 64,
  parameter int INSTR_W    = 32,
  parameter int N_RANGES   = 4,
  parameter int N_EVENTS   = 8,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter logic [INSTR_W-1:0] WFI_INSTR = 32'h10500073,
  parameter int PKT_W      = INSTR_W + TS_W + XLEN + N_EVENTS * CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pc_valid,
  input  logic [XLEN-1:0]     pc,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [N_EVENTS-1:0] perf_events,
  input  logic                ctrl_we,
  input  logic [7:0]          ctrl_addr,
  input  logic [XLEN-1:0]     ctrl_wdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [PKT_W-1:0]    m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [1:0]          state,
  output logic [15:0]         overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRACING = 2'd2, STOPPED = 2'd3} state_t;

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a, input logic b);
    return (b && (a != {CNT_W{1'b1}})) ? a + CNT_W'(1) : a;
  endfunction

  function automatic logic [TS_W-1:0] ts_inc(input logic [TS_W-1:0] a);
    return (a != {TS_W{1'b1}}) ? a + TS_W'(1) : a;
  endfunction

  function automatic logic [15:0] ovf_inc(input logic [15:0] a);
    return (a != 16'hFFFF) ? a + 16'd1 : a;
  endfunction

  state_t               fsm;
  logic [XLEN-1:0]      start_addr, end_addr;
  logic [1:0]           trig_en;
  logic [15:0]          tlast_interval, beat_cnt;
  logic [N_RANGES-1:0]  range_en, range_excl;
  logic [XLEN-1:0]      range_lo [N_RANGES];
  logic [XLEN-1:0]      range_hi [N_RANGES];

  logic ctrl_hit, arm_bit, retire, start_hit, stop_hit, start_tr, stop_tr, capture;
  logic incl_any, incl_hit, excl_hit, range_pass, beat_clr;

  logic [CNT_W-1:0]            ev_acc [N_EVENTS];
  logic [CNT_W-1:0]            ev_sum [N_EVENTS];
  logic [N_EVENTS*CNT_W-1:0]   cnt_flat;
  logic [TS_W-1:0]             ts_acc, ts_sum;

  logic             vld_p0, stop_p0;
  logic [PKT_W-1:0] pkt_p0;

  logic [PKT_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, push_ok, drop, tlast_w;

  assign state    = fsm;
  assign ctrl_hit = ctrl_we && (ctrl_addr == 8'h00);
  assign arm_bit  = ctrl_wdata[0];
  assign retire   = pc_valid && en;
  assign beat_clr = ctrl_we && ((ctrl_addr == 8'h04) || (ctrl_hit && arm_bit));

  // A CTRL write wins over a same-cycle retire, so it suppresses trigger transitions.
  assign start_hit = (fsm == ARMED) && (!trig_en[0] || (pc == start_addr));
  assign stop_hit  = (fsm == TRACING) && ((trig_en[1] && (pc == end_addr)) || (instr == WFI_INSTR));
  assign start_tr  = retire && !ctrl_hit && start_hit;
  assign stop_tr   = retire && !ctrl_hit && stop_hit;
  assign capture   = retire && range_pass &&
                     (ctrl_hit ? (arm_bit && (fsm == TRACING)) : (start_hit || (fsm == TRACING)));

  always_comb begin
    incl_any = 1'b0;
    incl_hit = 1'b0;
    excl_hit = 1'b0;
    for (int i = 0; i < N_RANGES; i++) begin
      if (range_en[i] && !range_excl[i]) begin
        incl_any = 1'b1;
        if ((pc >= range_lo[i]) && (pc <= range_hi[i])) incl_hit = 1'b1;
      end
      if (range_en[i] && range_excl[i] && (pc >= range_lo[i]) && (pc <= range_hi[i])) excl_hit = 1'b1;
    end
    range_pass = (!incl_any || incl_hit) && !excl_hit;
  end

  // Accumulators restart only when a packet actually enters the FIFO; drops keep them running.
  always_comb begin
    cnt_flat = '0;
    for (int k = 0; k < N_EVENTS; k++) begin
      ev_sum[k] = cnt_add(push_ok ? '0 : ev_acc[k], perf_events[k]);
      cnt_flat[(N_EVENTS-1-k)*CNT_W +: CNT_W] = ev_sum[k];
    end
    ts_sum = ts_inc((push_ok || start_tr) ? '0 : ts_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
    end else if (ctrl_hit) begin
      if (!arm_bit) fsm <= IDLE;
      else if ((fsm == IDLE) || (fsm == STOPPED)) fsm <= ARMED;
    end else if (start_tr) begin
      fsm <= TRACING;
    end else if (stop_tr) begin
      fsm <= STOPPED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr     <= '0;
      end_addr       <= '1;
      trig_en        <= '0;
      tlast_interval <= '0;
      range_en       <= '0;
      range_excl     <= '0;
      for (int i = 0; i < N_RANGES; i++) begin
        range_lo[i] <= '0;
        range_hi[i] <= '1;
      end
    end else if (ctrl_we) begin
      case (ctrl_addr)
        8'h01:   start_addr     <= ctrl_wdata;
        8'h02:   end_addr       <= ctrl_wdata;
        8'h03:   trig_en        <= ctrl_wdata[1:0];
        8'h04:   tlast_interval <= ctrl_wdata[15:0];
        8'h05:   range_en       <= ctrl_wdata[N_RANGES-1:0];
        8'h06:   range_excl     <= ctrl_wdata[N_RANGES-1:0];
        default: ;
      endcase
      for (int i = 0; i < N_RANGES; i++) begin
        if (ctrl_addr == 8'(8'h10 + 2*i)) range_lo[i] <= ctrl_wdata;
        if (ctrl_addr == 8'(8'h11 + 2*i)) range_hi[i] <= ctrl_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_acc <= '0;
      for (int k = 0; k < N_EVENTS; k++) ev_acc[k] <= '0;
    end else begin
      ts_acc <= ts_sum;
      for (int k = 0; k < N_EVENTS; k++) ev_acc[k] <= ev_sum[k];
    end
  end

  // ---- stage p0: capture registered, written to the FIFO next cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= capture;
  end

  always_ff @(posedge clk) begin
    pkt_p0  <= {instr, ts_sum, pc, cnt_flat};
    stop_p0 <= stop_tr;
  end

  // ---- FIFO write / AXI-Stream read ----
  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push_ok       = vld_p0 && (!full || pop);
  assign drop          = vld_p0 && full && !pop;
  assign tlast_w       = stop_p0 || ((tlast_interval != 16'd0) && (beat_cnt == tlast_interval - 16'd1));
  assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {tlast_w, pkt_p0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      beat_cnt       <= '0;
      overflow_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (beat_clr)     beat_cnt <= '0;
      else if (push_ok) beat_cnt <= tlast_w ? 16'd0 : beat_cnt + 16'd1;
      if (ctrl_hit && ctrl_wdata[1]) overflow_count <= '0;
      else if (drop)                 overflow_count <= ovf_inc(overflow_count);
    end
  end

endmodule

// File: tb/tb_trace_capture_engine.sv
// Randomized bench for trace_capture_engine against a cycle-stamped queue reference model.
module tb_trace_capture_engine;
  localparam int XLEN = 64, INSTR_W = 32, NR = 4, NE = 8, CNT_W = 8, TS_W = 32, DEPTH = 16;
  localparam int PKT_W = INSTR_W + TS_W + XLEN + NE * CNT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] WFI = 32'h10500073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 0, rst_n = 0, en = 0, pc_valid = 0;
  logic [XLEN-1:0] pc = '0;
  logic [INSTR_W-1:0] instr = '0;
  logic [NE-1:0] perf_events = '0;
  logic ctrl_we = 0;
  logic [7:0] ctrl_addr = '0;
  logic [XLEN-1:0] ctrl_wdata = '0;
  logic m_axis_tready = 0;
  logic m_axis_tvalid, m_axis_tlast;
  logic [PKT_W-1:0] m_axis_tdata;
  logic [1:0] state;
  logic [15:0] overflow_count;

  trace_capture_engine #(.XLEN(XLEN), .INSTR_W(INSTR_W), .N_RANGES(NR), .N_EVENTS(NE),
    .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_valid(pc_valid), .pc(pc), .instr(instr),
    .perf_events(perf_events), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .state(state), .overflow_count(overflow_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int pops = 0, lasts = 0;
  int ev_mode = 0;
  bit chk_on = 0;

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected FIFO contents as a queue of {tlast, packet}
  logic [PKT_W:0] mq[$];
  int m_state = 0, m_ovf = 0, m_beats = 0;
  longint cyc = 0, ts_ref = 0;
  int ev[NE];
  bit m_pend = 0, m_pend_stop = 0;
  logic [PKT_W-1:0] m_pend_pkt = '0;
  logic [XLEN-1:0] r_start, r_end;
  logic [XLEN-1:0] r_lo[NR];
  logic [XLEN-1:0] r_hi[NR];
  logic [1:0] r_trig;
  int r_intv;
  logic [NR-1:0] r_en, r_ex;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      mq.delete();
      m_state = 0; m_ovf = 0; m_beats = 0; m_pend = 0; m_pend_stop = 0;
      r_start = '0; r_end = '1; r_trig = '0; r_intv = 0; r_en = '0; r_ex = '0;
      for (int i = 0; i < NR; i++) begin r_lo[i] = '0; r_hi[i] = '1; end
      for (int k = 0; k < NE; k++) ev[k] = 0;
      ts_ref = cyc;
    end else begin
      bit pop, acc, tl, retire, fw, any_inc, hit_inc, hit_ex, in_r, pass, cap, stp;
      int nxt;
      longint ts;
      logic [NE*CNT_W-1:0] cf;
      pop = (mq.size() > 0) && m_axis_tready;
      acc = 0;
      if (m_pend) begin
        if (mq.size() < DEPTH || pop) begin
          acc = 1;
          tl = m_pend_stop || (r_intv != 0 && m_beats + 1 == r_intv);
          m_beats = tl ? 0 : m_beats + 1;
          mq.push_back({tl, m_pend_pkt});
        end else if (m_ovf < 65535) m_ovf++;
      end
      if (pop) void'(mq.pop_front());
      if (acc) begin
        ts_ref = cyc - 1;
        for (int k = 0; k < NE; k++) ev[k] = 0;
      end
      for (int k = 0; k < NE; k++) ev[k] += int'(perf_events[k]);
      retire = pc_valid && en;
      fw = ctrl_we && (ctrl_addr == 8'h00);
      any_inc = 0; hit_inc = 0; hit_ex = 0;
      for (int i = 0; i < NR; i++) begin
        in_r = (pc >= r_lo[i]) && (pc <= r_hi[i]);
        if (r_en[i] && !r_ex[i]) begin any_inc = 1; if (in_r) hit_inc = 1; end
        if (r_en[i] && r_ex[i] && in_r) hit_ex = 1;
      end
      pass = (!any_inc || hit_inc) && !hit_ex;
      nxt = m_state; cap = 0; stp = 0;
      if (fw) begin
        if (!ctrl_wdata[0]) nxt = 0;
        else if (m_state == 0 || m_state == 3) nxt = 1;
        cap = retire && pass && ctrl_wdata[0] && (m_state == 2);
      end else if (retire) begin
        if (m_state == 1 && (!r_trig[0] || pc == r_start)) begin
          nxt = 2; ts_ref = cyc - 1; cap = pass;
        end else if (m_state == 2) begin
          cap = pass;
          if ((r_trig[1] && pc == r_end) || instr == WFI) begin nxt = 3; stp = 1; end
        end
      end
      if (cap) begin
        ts = cyc - ts_ref;
        if (ts > 64'hFFFF_FFFF) ts = 64'hFFFF_FFFF;
        for (int k = 0; k < NE; k++)
          cf[(NE-1-k)*CNT_W +: CNT_W] = CNT_W'((ev[k] > CMAX) ? CMAX : ev[k]);
        m_pend_pkt = {instr, ts[TS_W-1:0], pc, cf};
      end
      m_pend = cap; m_pend_stop = stp;
      m_state = nxt;
      if (ctrl_we) begin
        case (ctrl_addr)
          8'h00: begin if (ctrl_wdata[1]) m_ovf = 0; if (ctrl_wdata[0]) m_beats = 0; end
          8'h01: r_start = ctrl_wdata;
          8'h02: r_end = ctrl_wdata;
          8'h03: r_trig = ctrl_wdata[1:0];
          8'h04: begin r_intv = int'(ctrl_wdata[15:0]); m_beats = 0; end
          8'h05: r_en = ctrl_wdata[NR-1:0];
          8'h06: r_ex = ctrl_wdata[NR-1:0];
          default: ;
        endcase
        for (int i = 0; i < NR; i++) begin
          if (int'(ctrl_addr) == 16 + 2*i) r_lo[i] = ctrl_wdata;
          if (int'(ctrl_addr) == 17 + 2*i) r_hi[i] = ctrl_wdata;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("state", PKT_W'(state), PKT_W'(m_state));
      chk("overflow_count", PKT_W'(overflow_count), PKT_W'(m_ovf));
      chk("tvalid", PKT_W'(m_axis_tvalid), PKT_W'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("tdata", m_axis_tdata, mq[0][PKT_W-1:0]);
        chk("tlast", PKT_W'(m_axis_tlast), PKT_W'(mq[0][PKT_W]));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      pops++;
      if (m_axis_tlast) lasts++;
    end
  end

  always @(negedge clk) begin
    case (ev_mode)
      1:       perf_events = NE'($urandom);
      2:       perf_events = NE'(1);
      default: perf_events = '0;
    endcase
  end

  task automatic wr(input logic [7:0] a, input logic [XLEN-1:0] d);
    ctrl_we = 1; ctrl_addr = a; ctrl_wdata = d;
    @(negedge clk);
    ctrl_we = 0;
  endtask

  task automatic ret(input logic [XLEN-1:0] p, input logic [INSTR_W-1:0] ins);
    pc_valid = 1; pc = p; instr = ins;
    @(negedge clk);
    pc_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_axis_tready = 1; pc_valid = 0; ctrl_we = 0;
    idle(3);
    while (m_axis_tvalid && n < 200) begin @(negedge clk); n++; end
    chk("drain_done", PKT_W'(m_axis_tvalid), '0);
  endtask

  task automatic rand_run(input int n, input int rdy_pct);
    for (int c = 0; c < n; c++) begin
      en = ($urandom_range(0, 9) != 0);
      pc_valid = ($urandom_range(0, 9) < 6);
      pc = XLEN'($urandom_range(0, 63)) << 2;
      instr = ($urandom_range(0, 49) == 0) ? WFI : INSTR_W'($urandom);
      m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
      ctrl_we = 0;
      if ($urandom_range(0, 39) == 0) begin
        ctrl_we = 1; ctrl_addr = 8'h00;
        ctrl_wdata = {62'd0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0)};
      end else if ($urandom_range(0, 199) == 0) begin
        ctrl_we = 1; ctrl_addr = 8'h04; ctrl_wdata = XLEN'($urandom_range(0, 5));
      end
      @(negedge clk);
    end
    ctrl_we = 0; pc_valid = 0; en = 1;
  endtask

  initial begin
    int p0, l0;
    en = 1; m_axis_tready = 1;
    idle(3);
    chk("rst_tvalid", PKT_W'(m_axis_tvalid), '0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tlast", PKT_W'(m_axis_tlast), '0);
    chk("rst_state", PKT_W'(state), '0);
    chk("rst_ovf", PKT_W'(overflow_count), '0);
    rst_n = 1; chk_on = 1;
    idle(1);

    // back-to-back captures, ending with WFI, then again without WFI
    wr(8'h00, 64'h1);
    ret(64'h100, NOP); ret(64'h104, NOP); ret(64'h108, WFI);
    idle(4);
    chk("t1_stopped", PKT_W'(state), PKT_W'(3));
    wr(8'h00, 64'h1);
    ret(64'h100, NOP); ret(64'h104, NOP); ret(64'h108, NOP);
    idle(4);
    chk("t1_tracing", PKT_W'(state), PKT_W'(2));
    wr(8'h00, 64'h0);

    // start / end triggers
    wr(8'h01, 64'h200); wr(8'h03, 64'h1); wr(8'h00, 64'h1);
    ret(64'h1F0, NOP);
    chk("t2_armed", PKT_W'(state), PKT_W'(1));
    ret(64'h200, NOP);
    chk("t2_tracing", PKT_W'(state), PKT_W'(2));
    wr(8'h02, 64'h300); wr(8'h03, 64'h3);
    ret(64'h204, NOP); ret(64'h300, NOP);
    idle(3);
    chk("t2_stopped", PKT_W'(state), PKT_W'(3));
    wr(8'h03, 64'h0);

    // include/exclude ranges
    wr(8'h10, 64'h1000); wr(8'h11, 64'h1FFF); wr(8'h12, 64'h1800); wr(8'h13, 64'h18FF);
    wr(8'h06, 64'h2); wr(8'h05, 64'h3); wr(8'h00, 64'h0); wr(8'h00, 64'h1);
    idle(3);
    p0 = pops;
    ret(64'h0FFC, NOP); ret(64'h1000, NOP); ret(64'h1804, NOP); ret(64'h1FFF, NOP);
    idle(5);
    chk("t3_beats", PKT_W'(pops - p0), PKT_W'(2));
    wr(8'h05, 64'h0);

    // overflow with stalled stream; next packet spans the dropped interval
    wr(8'h00, 64'h0); wr(8'h00, 64'h1);
    m_axis_tready = 0; ev_mode = 1;
    for (int i = 0; i < DEPTH + 3; i++) ret(64'h400 + 64'(4*i), NOP);
    idle(3);
    chk("t4_ovf", PKT_W'(overflow_count), PKT_W'(3));
    idle(20);
    drain();
    ret(64'h500, NOP);
    drain();
    wr(8'h00, 64'h3);
    chk("t4_ovf_clr", PKT_W'(overflow_count), '0);

    // tlast interval and counter saturation
    ev_mode = 0;
    wr(8'h04, 64'd4); wr(8'h00, 64'h0); wr(8'h00, 64'h1);
    l0 = lasts;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin ev_mode = 2; idle(300); ev_mode = 0; end
      ret(64'h600 + 64'(4*i), (i == 9) ? WFI : NOP);
      idle($urandom_range(0, 3));
    end
    idle(5);
    chk("t5_tlast_beats", PKT_W'(lasts - l0), PKT_W'(3));

    // reset while a beat is stalled
    wr(8'h04, 64'd0); wr(8'h00, 64'h1);
    m_axis_tready = 0;
    for (int i = 0; i < 5; i++) ret(64'h700 + 64'(4*i), NOP);
    idle(3);
    chk("t6_pre_tvalid", PKT_W'(m_axis_tvalid), PKT_W'(1));
    chk_on = 0;
    #2 rst_n = 0;
    #1 chk("t6_async_tvalid", PKT_W'(m_axis_tvalid), '0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_state", PKT_W'(state), '0);
    chk_on = 1;
    m_axis_tready = 1;
    for (int i = 0; i < 5; i++) ret(64'h700 + 64'(4*i), NOP);
    drain();

    // randomized traffic
    ev_mode = 1;
    wr(8'h10, 64'h40); wr(8'h11, 64'hBF); wr(8'h12, 64'h60); wr(8'h13, 64'h7F);
    wr(8'h14, 64'hE0); wr(8'h15, 64'hFC);
    wr(8'h05, 64'h7); wr(8'h06, 64'h2);
    wr(8'h01, 64'h40); wr(8'h02, 64'hF0); wr(8'h03, 64'h3); wr(8'h04, 64'd5);
    wr(8'h00, 64'h1);
    rand_run(1000, 80);
    rand_run(400, 15);
    wr(8'h03, 64'h0); wr(8'h05, 64'h0);
    rand_run(1000, 70);
    wr(8'h05, 64'h5);
    rand_run(600, 40);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
